mem_burst_ctrl: RTL and testbench
=================================

// Module: mem_burst_ctrl
// PURPOSE
//  Burst sequencer sitting directly upstream of the single-port memory (valid/ready, wr_rd select).
//  Accepts one command {wr/rd, start addr, length}, issues one memory access per word and streams data.
//  Write data enters on a valid/ready stream. Read data leaves on a valid/ready stream through a 2-entry buffer.
// PARAMETERS
//  WIDTH       32                 data width, equal to memory WIDTH
//  DEPTH       1024               memory depth in words
//  ADDR_WIDTH  $clog2(DEPTH)      memory address width
//  LEN_WIDTH   ADDR_WIDTH+1       burst length width (0..DEPTH words)
// PORTS
//  clk            in   1           single clock, all logic on posedge
//  rst            in   1           synchronous reset, active-high
//  cmd_valid_i    in   1           command offered
//  cmd_ready_o    out  1           command accepted when valid&ready; high only in IDLE
//  cmd_wr_i       in   1           1=write burst, 0=read burst
//  cmd_addr_i     in   ADDR_WIDTH  start address
//  cmd_len_i      in   LEN_WIDTH   number of words
//  wdata_valid_i  in   1           write data word offered
//  wdata_ready_o  out  1           write word consumed (= mem transfer in WRITE)
//  wdata_i        in   WIDTH       write data
//  rdata_valid_o  out  1           read word available
//  rdata_ready_i  in   1           downstream takes read word
//  rdata_o        out  WIDTH       read data
//  rdata_last_o   out  1           marks final word of read burst
//  done_o         out  1           1-cycle pulse, burst complete
//  err_o          out  1           1-cycle pulse, command rejected (MEM_BOUND_CHK_EN only; else tied 0)
//  mem_valid_o    out  1           to memory valid_i
//  mem_wr_rd_o    out  1           to memory wr_rd_i
//  mem_addr_o     out  ADDR_WIDTH  to memory addr_i
//  mem_wr_data_o  out  WIDTH       to memory wr_data_i
//  mem_rd_data_i  in   WIDTH       from memory rd_data_o, valid 1 cycle after read transfer
//  mem_ready_i    in   1           from memory ready_o
// BEHAVIOUR
//  - Reset (rst=1 at posedge): FSM->IDLE; counters, buffer cleared; every output 0 except cmd_ready_o=1.
//  - Mem transfer = mem_valid_o & mem_ready_i. Address increments per transfer, wraps DEPTH-1 -> 0.
//  - States: IDLE, WRITE, READ, DRAIN.
//    IDLE : cmd accept: len=0 -> done_o next cycle, stay IDLE. cmd_wr_i=1 -> WRITE. Else -> READ.
//    WRITE: mem_valid_o=wdata_valid_i; mem_wr_rd_o=1; mem_wr_data_o=wdata_i (combinational pass).
//           After the last transfer, go to IDLE and pulse done_o in the same cycle as that transfer.
//    READ : mem_valid_o=1 only if (buffered + in-flight) < 2. Buffer never overflows.
//           After the last transfer -> DRAIN.
//    DRAIN: wait until the last word has left the buffer (rdata_valid_o&rdata_ready_i&rdata_last_o).
//           done_o pulses that cycle; then -> IDLE.
//  - Read latency: mem_rd_data_i is captured into the buffer 1 cycle after the transfer.
//    rdata_valid_o is earliest the cycle after capture.
//  - Buffer full and the in-flight word arrives: cannot occur, guaranteed by the issue rule.
//  - Enqueue and dequeue in the same cycle: both happen and occupancy is unchanged.
//  - mem_valid_o, mem_addr_o, mem_wr_rd_o are held stable while mem_ready_i=0.
//  - rst mid-burst: abort immediately. Pending read data is discarded. No done_o.
//  - cmd_* inputs are ignored outside IDLE. Word counter width is LEN_WIDTH; len=DEPTH is legal.
// CONFIGURATION
//  MEM_BOUND_CHK_EN defined: a command with cmd_addr_i+cmd_len_i > DEPTH is accepted but not executed.
//    err_o pulses the next cycle, no mem access, no done_o.
//  MEM_BOUND_CHK_EN undefined: no check; bursts wrap at DEPTH; err_o tied 0.
// STRUCTURE
//  Package mem_burst_pkg: state enum {IDLE,WRITE,READ,DRAIN}; RD_BUF_DEPTH=2; MEM_RD_LATENCY=1.
//  Sub-module mem_burst_rd_buf: 2-entry valid/ready FIFO {data,last}.
//    Exposes count to the issue-rule logic.
// TESTING
//  1 Write addr=0 len=4, data 0x11,0x22,0x33,0x44, mem_ready_i=1 -> 4 writes at addr 0..3, done_o after the 4th.
//  2 Read addr=0 len=4, rdata_ready_i=1 -> rdata_o 0x11,0x22,0x33,0x44.
//    rdata_last_o on 0x44; done_o with that beat.
//  3 Read len=8 with rdata_ready_i toggling 1/0 and mem_ready_i randomly low.
//    -> no word lost or duplicated; mem_valid_o never issued while buffer+in-flight=2.
//  4 Write addr=DEPTH-2 len=4 (no MEM_BOUND_CHK_EN) -> addresses 1022,1023,0,1.
//    With the macro defined -> err_o pulse, zero mem transfers.
//  5 Command len=0 -> done_o pulses 1 cycle after accept; mem_valid_o stays 0.
//  6 Assert rst during READ word 3 of 8 -> next cycle all outputs 0, cmd_ready_o=1.
//    A new write burst then completes normally.

Source files
------------

// File: rtl/mem_burst_pkg.sv
// Shared types and constants for the burst sequencer and its read buffer.
// Optional bound checking is selected with the MEM_BOUND_CHK_EN macro in mem_burst_ctrl.
package mem_burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int RD_BUF_DEPTH   = 2;
    localparam int MEM_RD_LATENCY = 1;
    localparam int RD_CNT_W       = $clog2(RD_BUF_DEPTH + 1);

    // True when the burst [addr, addr+len) fits below depth without wrapping.
    function automatic logic burst_in_bounds(input int unsigned addr,
                                             input int unsigned len,
                                             input int unsigned depth);
        return (addr + len) <= depth;
    endfunction

endpackage

// File: rtl/mem_burst_ctrl_if.sv
// Bundle of command, write-stream, read-stream and memory-side signals of the burst sequencer.
// slave = the sequencer itself, master = the surrounding system (command source, streams, memory).
interface mem_burst_ctrl_if #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_wr_i;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic [LEN_WIDTH-1:0]  cmd_len_i;

    logic                  wdata_valid_i;
    logic                  wdata_ready_o;
    logic [WIDTH-1:0]      wdata_i;

    logic                  rdata_valid_o;
    logic                  rdata_ready_i;
    logic [WIDTH-1:0]      rdata_o;
    logic                  rdata_last_o;

    logic                  done_o;
    logic                  err_o;

    logic                  mem_valid_o;
    logic                  mem_wr_rd_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [WIDTH-1:0]      mem_wr_data_o;
    logic [WIDTH-1:0]      mem_rd_data_i;
    logic                  mem_ready_i;

    modport slave (
        input  cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_len_i,
        input  wdata_valid_i, wdata_i,
        input  rdata_ready_i,
        input  mem_rd_data_i, mem_ready_i,
        output cmd_ready_o, wdata_ready_o,
        output rdata_valid_o, rdata_o, rdata_last_o,
        output done_o, err_o,
        output mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wr_data_o
    );

    modport master (
        output cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_len_i,
        output wdata_valid_i, wdata_i,
        output rdata_ready_i,
        output mem_rd_data_i, mem_ready_i,
        input  cmd_ready_o, wdata_ready_o,
        input  rdata_valid_o, rdata_o, rdata_last_o,
        input  done_o, err_o,
        input  mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wr_data_o
    );

endinterface

// File: rtl/mem_burst_rd_buf.sv
// Two-entry valid/ready FIFO holding {data, last} read words; its occupancy feeds the read issue rule.
module mem_burst_rd_buf
    import mem_burst_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [WIDTH-1:0]    push_data,
    input  logic                push_last,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_last,
    output logic [RD_CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(RD_BUF_DEPTH);

    logic [WIDTH-1:0] data_q [RD_BUF_DEPTH];
    logic             last_q [RD_BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [RD_CNT_W-1:0] count_q;
    logic             pop;

    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    // Empty entries read as zero so stale words never appear on the stream after a reset.
    assign out_data = out_valid ? data_q[rd_ptr_q] : '0;
    assign out_last = out_valid && last_q[rd_ptr_q];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + RD_CNT_W'(1);
                2'b01:   count_q <= count_q - RD_CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage has no reset; the occupancy counter alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q] <= push_data;
            last_q[wr_ptr_q] <= push_last;
        end
    end

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst sequencer in front of a single-port valid/ready memory: one command, one access per word.
// Define MEM_BOUND_CHK_EN to reject commands whose burst would run past the top of memory.
module mem_burst_ctrl
    import mem_burst_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input logic             clk,
    input logic             rst,
    mem_burst_ctrl_if.slave bus
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_inc;
    logic [LEN_WIDTH-1:0]  remain_q, remain_d;
    logic                  in_flight_q, in_flight_last_q;
    logic                  len0_done_q, len0_done_d;
    logic                  err_q, err_d;
    logic                  bound_err;
    logic                  last_xfer;
    logic                  rd_xfer;
    logic                  burst_done;
    logic                  buf_room;

    logic                  cmd_ready;
    logic                  wdata_ready;
    logic                  mem_valid;
    logic                  mem_wr_rd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_wr_data;

    logic                  rdata_valid;
    logic [WIDTH-1:0]      rdata;
    logic                  rdata_last;
    logic [RD_CNT_W-1:0]   buf_count;

`ifdef MEM_BOUND_CHK_EN
    assign bound_err = !burst_in_bounds(32'(bus.cmd_addr_i), 32'(bus.cmd_len_i), DEPTH);
`else
    assign bound_err = 1'b0;
`endif

    assign addr_inc  = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
    assign last_xfer = (remain_q == LEN_WIDTH'(1));

    // Buffered words plus the word still coming back from memory must leave a free slot.
    assign buf_room = (int'(buf_count) + int'(in_flight_q)) < RD_BUF_DEPTH;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        len0_done_d = 1'b0;
        err_d       = 1'b0;
        rd_xfer     = 1'b0;
        burst_done  = 1'b0;
        cmd_ready   = 1'b0;
        wdata_ready = 1'b0;
        mem_valid   = 1'b0;
        mem_wr_rd   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid_i) begin
                    if (bus.cmd_len_i == '0) begin
                        len0_done_d = 1'b1;
                    end else if (bound_err) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d   = bus.cmd_addr_i;
                        remain_d = bus.cmd_len_i;
                        state_d  = bus.cmd_wr_i ? WRITE : READ;
                    end
                end
            end

            WRITE: begin
                mem_valid   = bus.wdata_valid_i;
                mem_wr_rd   = 1'b1;
                mem_addr    = addr_q;
                mem_wr_data = bus.wdata_i;
                if (bus.wdata_valid_i && bus.mem_ready_i) begin
                    wdata_ready = 1'b1;
                    addr_d      = addr_inc;
                    remain_d    = remain_q - LEN_WIDTH'(1);
                    if (last_xfer) begin
                        burst_done = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end

            READ: begin
                mem_valid = buf_room;
                mem_addr  = addr_q;
                if (buf_room && bus.mem_ready_i) begin
                    rd_xfer  = 1'b1;
                    addr_d   = addr_inc;
                    remain_d = remain_q - LEN_WIDTH'(1);
                    if (last_xfer) state_d = DRAIN;
                end
            end

            DRAIN: begin
                if (rdata_valid && bus.rdata_ready_i && rdata_last) begin
                    burst_done = 1'b1;
                    state_d    = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            addr_q           <= '0;
            remain_q         <= '0;
            in_flight_q      <= 1'b0;
            in_flight_last_q <= 1'b0;
            len0_done_q      <= 1'b0;
            err_q            <= 1'b0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            remain_q         <= remain_d;
            in_flight_q      <= rd_xfer;
            in_flight_last_q <= rd_xfer && last_xfer;
            len0_done_q      <= len0_done_d;
            err_q            <= err_d;
        end
    end

    // Memory returns read data one cycle after the transfer; it is captured on that cycle's edge.
    mem_burst_rd_buf #(
        .WIDTH (WIDTH)
    ) u_rd_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (in_flight_q),
        .push_data (bus.mem_rd_data_i),
        .push_last (in_flight_last_q),
        .out_ready (bus.rdata_ready_i),
        .out_valid (rdata_valid),
        .out_data  (rdata),
        .out_last  (rdata_last),
        .count     (buf_count)
    );

    assign bus.cmd_ready_o   = cmd_ready;
    assign bus.wdata_ready_o = wdata_ready;
    assign bus.rdata_valid_o = rdata_valid;
    assign bus.rdata_o       = rdata;
    assign bus.rdata_last_o  = rdata_last;
    assign bus.done_o        = burst_done || len0_done_q;
    assign bus.err_o         = err_q;
    assign bus.mem_valid_o   = mem_valid;
    assign bus.mem_wr_rd_o   = mem_wr_rd;
    assign bus.mem_addr_o    = mem_addr;
    assign bus.mem_wr_data_o = mem_wr_data;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl with a behavioural memory and write/read scoreboards.
// Build with +define+MEM_BOUND_CHK_EN to exercise the bound-check variant of the wrap test.
module tb_mem_burst_ctrl;

    localparam int WIDTH = 32;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int LW    = 11;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_burst_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    mem_burst_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0]    mem_model [DEPTH];
    logic [WIDTH-1:0]    ref_mem   [DEPTH];
    logic [AW+WIDTH-1:0] exp_wr_q  [$];
    logic [WIDTH:0]      exp_rd_q  [$];

    int          outstanding = 0;
    int          rd_issued   = 0;
    logic        prev_stall  = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic        prev_wr_rd  = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Single-port memory with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.mem_valid_o && bus.mem_ready_i) begin
            if (bus.mem_wr_rd_o) mem_model[bus.mem_addr_o] <= bus.mem_wr_data_o;
            else                 bus.mem_rd_data_i <= mem_model[bus.mem_addr_o];
        end
    end

    // Scoreboard, issue-rule and hold checks, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            exp_wr_q.delete();
            exp_rd_q.delete();
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            logic rd_x, deq;
            rd_x = bus.mem_valid_o && bus.mem_ready_i && !bus.mem_wr_rd_o;
            deq  = bus.rdata_valid_o && bus.rdata_ready_i;
            if (prev_stall) begin
                check("hold_valid", bus.mem_valid_o, 1);
                check("hold_addr", bus.mem_addr_o, prev_addr);
                check("hold_wr_rd", bus.mem_wr_rd_o, prev_wr_rd);
            end
            if (bus.mem_valid_o && !bus.mem_wr_rd_o)
                check("issue_rule", outstanding < 2, 1);
            if (bus.mem_valid_o && bus.mem_ready_i && bus.mem_wr_rd_o) begin
                if (exp_wr_q.size() == 0) check("wr_unexpected", 1, 0);
                else begin
                    logic [AW+WIDTH-1:0] e;
                    e = exp_wr_q.pop_front();
                    check("wr_addr", bus.mem_addr_o, e[AW+WIDTH-1:WIDTH]);
                    check("wr_data", bus.mem_wr_data_o, e[WIDTH-1:0]);
                end
            end
            if (deq) begin
                if (exp_rd_q.size() == 0) check("rd_unexpected", 1, 0);
                else begin
                    logic [WIDTH:0] e;
                    e = exp_rd_q.pop_front();
                    check("rd_data", bus.rdata_o, e[WIDTH-1:0]);
                    check("rd_last", bus.rdata_last_o, e[WIDTH]);
                end
            end
            outstanding = outstanding + int'(rd_x) - int'(deq);
            rd_issued   = rd_issued + int'(rd_x);
            prev_stall  = bus.mem_valid_o && !bus.mem_ready_i;
            prev_addr   = bus.mem_addr_o;
            prev_wr_rd  = bus.mem_wr_rd_o;
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cmd_ready"}, bus.cmd_ready_o, 1);
        check({tag, "_wdata_ready"}, bus.wdata_ready_o, 0);
        check({tag, "_rdata_valid"}, bus.rdata_valid_o, 0);
        check({tag, "_rdata"}, bus.rdata_o, 0);
        check({tag, "_rdata_last"}, bus.rdata_last_o, 0);
        check({tag, "_done"}, bus.done_o, 0);
        check({tag, "_err"}, bus.err_o, 0);
        check({tag, "_mem_valid"}, bus.mem_valid_o, 0);
        check({tag, "_mem_wr_rd"}, bus.mem_wr_rd_o, 0);
        check({tag, "_mem_addr"}, bus.mem_addr_o, 0);
        check({tag, "_mem_wr_data"}, bus.mem_wr_data_o, 0);
    endtask

    // Offers a command for one cycle; returns just after the accepting edge.
    task automatic send_cmd(input logic wr, input int addr, input int len);
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_wr_i    = wr;
        bus.cmd_addr_i  = AW'(addr);
        bus.cmd_len_i   = LW'(len);
        @(negedge clk);
        check("cmd_ready", bus.cmd_ready_o, 1);
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic write_burst(input int addr, input int len, input logic [WIDTH-1:0] seed);
        for (int i = 0; i < len; i++) begin
            logic [WIDTH-1:0] d;
            d = WIDTH'(seed * WIDTH'(i + 1));
            exp_wr_q.push_back({AW'((addr + i) % DEPTH), d});
            ref_mem[(addr + i) % DEPTH] = d;
        end
        bus.mem_ready_i = 1'b1;
        send_cmd(1'b1, addr, len);
        for (int i = 0; i < len; i++) begin
            logic ok;
            bus.wdata_valid_i = 1'b1;
            bus.wdata_i       = WIDTH'(seed * WIDTH'(i + 1));
            ok = 1'b0;
            for (int t = 0; t < 50 && !ok; t++) begin
                @(negedge clk);
                if (bus.wdata_ready_o) ok = 1'b1;
                else begin @(posedge clk); #1; end
            end
            check("wr_accept", ok, 1);
            check("wr_done", bus.done_o, (i == len - 1));
            @(posedge clk); #1;
        end
        bus.wdata_valid_i = 1'b0;
        @(negedge clk);
        check("wr_done_clear", bus.done_o, 0);
        check("wr_queue_empty", exp_wr_q.size(), 0);
    endtask

    task automatic read_burst(input int addr, input int len, input logic jitter);
        logic got_done;
        for (int i = 0; i < len; i++)
            exp_rd_q.push_back({(i == len - 1), ref_mem[(addr + i) % DEPTH]});
        bus.mem_ready_i   = 1'b1;
        bus.rdata_ready_i = 1'b1;
        send_cmd(1'b0, addr, len);
        got_done = 1'b0;
        for (int t = 0; t < 400 && !got_done; t++) begin
            @(negedge clk);
            if (bus.done_o) begin
                got_done = 1'b1;
                check("rd_done_on_last",
                      bus.rdata_valid_o && bus.rdata_ready_i && bus.rdata_last_o, 1);
            end
            @(posedge clk); #1;
            if (jitter) begin
                bus.rdata_ready_i = ~bus.rdata_ready_i;
                bus.mem_ready_i   = 1'($urandom_range(0, 1));
            end
        end
        check("rd_done_seen", got_done, 1);
        check("rd_queue_empty", exp_rd_q.size(), 0);
        bus.mem_ready_i   = 1'b1;
        bus.rdata_ready_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        int  base;
        logic ok;

        rst = 1'b1;
        bus.cmd_valid_i   = 1'b0;
        bus.cmd_wr_i      = 1'b0;
        bus.cmd_addr_i    = '0;
        bus.cmd_len_i     = '0;
        bus.wdata_valid_i = 1'b0;
        bus.wdata_i       = '0;
        bus.rdata_ready_i = 1'b0;
        bus.mem_ready_i   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic write then read-back.
        write_burst(0, 4, 32'h11);
        read_burst(0, 4, 1'b0);

        // Read with downstream and memory back-pressure.
        write_burst(16, 8, 32'hA5);
        read_burst(16, 8, 1'b1);

        // Burst crossing the top of memory.
`ifdef MEM_BOUND_CHK_EN
        send_cmd(1'b1, DEPTH - 2, 4);
        bus.wdata_valid_i = 1'b1;
        bus.wdata_i       = 32'hDEAD_0001;
        @(negedge clk);
        check("bound_err_pulse", bus.err_o, 1);
        check("bound_no_done", bus.done_o, 0);
        check("bound_no_mem", bus.mem_valid_o, 0);
        @(negedge clk);
        check("bound_err_clear", bus.err_o, 0);
        check("bound_still_idle", bus.mem_valid_o, 0);
        @(posedge clk); #1;
        bus.wdata_valid_i = 1'b0;
`else
        write_burst(DEPTH - 2, 4, 32'h0B00);
        check("wrap_no_err", bus.err_o, 0);
        read_burst(DEPTH - 2, 4, 1'b0);
`endif

        // Zero-length command.
        send_cmd(1'b0, 5, 0);
        @(negedge clk);
        check("len0_done", bus.done_o, 1);
        check("len0_no_mem", bus.mem_valid_o, 0);
        @(negedge clk);
        check("len0_done_clear", bus.done_o, 0);
        check("len0_no_mem_after", bus.mem_valid_o, 0);
        check("len0_idle", bus.cmd_ready_o, 1);

        // Reset in the middle of a read burst, then a clean burst.
        for (int i = 0; i < 8; i++)
            exp_rd_q.push_back({(i == 7), ref_mem[16 + i]});
        bus.rdata_ready_i = 1'b0;
        bus.mem_ready_i   = 1'b1;
        base = rd_issued;
        send_cmd(1'b0, 16, 8);
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            if (rd_issued - base >= 2) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("rst_wait_two_issued", ok, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("midrst");
        write_burst(100, 3, 32'h5A5A_0001);
        read_burst(100, 3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
